// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: opcode numbers, ALU operation codes, default widths.
// Latency: n/a (constants and pure decode functions only).
// Backpressure: n/a.
package execute_stage_pkg;

   localparam int EX_DATA_W     = 32;
   localparam int EX_REG_ADDR_W = 3;

   // Opcodes 0-4 are register-register, 5-8 register-immediate, 9 load, 10 store.
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_OR   = 5'd2;
   localparam logic [4:0] OP_NOR  = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_SUBI = 5'd6;
   localparam logic [4:0] OP_ORI  = 5'd7;
   localparam logic [4:0] OP_ANDI = 5'd8;
   localparam logic [4:0] OP_LW   = 5'd9;
   localparam logic [4:0] OP_SW   = 5'd10;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_OR  = 3'b010,
      ALU_NOR = 3'b011,
      ALU_AND = 3'b100
   } alu_op_e;

   // Immediate forms, loads and stores take operand B from the immediate.
   function automatic logic uses_imm(input logic [4:0] op);
      return (op >= OP_ADDI) && (op <= OP_SW);
   endfunction

   // Everything up to and including the load writes a register; stores and unknown opcodes do not.
   function automatic logic writes_reg(input logic [4:0] op);
      return op <= OP_LW;
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of ID/EX inputs, writeback bypass, pipeline control and EX/MEM outputs.
// Latency: n/a (wiring only).
// Backpressure: hold/flush travel with the bundle; the stage itself never stalls upstream.
interface execute_stage_if
   import execute_stage_pkg::*;
#(
   parameter int DATA_W     = EX_DATA_W,
   parameter int REG_ADDR_W = EX_REG_ADDR_W
);
   logic                  in_valid;
   logic [4:0]            Opcode;
   logic [2:0]            ALUOP;
   logic [DATA_W-1:0]     rs_val;
   logic [DATA_W-1:0]     rt_val;
   logic [DATA_W-1:0]     imm;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [REG_ADDR_W-1:0] rs_addr;
   logic [REG_ADDR_W-1:0] rt_addr;
   logic                  wb_reg_write;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0]     wb_data;
   logic                  hold;
   logic                  flush;
   logic                  ex_valid;
   logic [DATA_W-1:0]     ex_result;
   logic [DATA_W-1:0]     ex_store_data;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_reg_write;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  ex_zero;

   modport master (
      output in_valid, Opcode, ALUOP, rs_val, rt_val, imm, rd_addr, rs_addr, rt_addr,
             wb_reg_write, wb_rd, wb_data, hold, flush,
      input  ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_zero
   );

   modport slave (
      input  in_valid, Opcode, ALUOP, rs_val, rt_val, imm, rd_addr, rs_addr, rt_addr,
             wb_reg_write, wb_rd, wb_data, hold, flush,
      output ex_valid, ex_result, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_zero
   );
endinterface

// File: rtl/execute_stage_alu_core.sv
// Combinational ALU: add, sub, or, nor, and; unused operation codes give zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu_core
   import execute_stage_pkg::*;
#(
   parameter int DATA_W = EX_DATA_W
)(
   input  logic [2:0]        aluop,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   // Select the operation; add/sub wrap and drop carry-out.
   always_comb begin
      result = '0;
      case (alu_op_e'(aluop))
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_OR:  result = a | b;
         ALU_NOR: result = ~(a | b);
         ALU_AND: result = a & b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand select (optional EX_FWD_EN bypass), ALU, and EX/MEM pipeline register.
// Latency: 1 cycle ID/EX -> ex_*; 1 instruction per cycle.
// Backpressure: hold freezes EX/MEM, flush inserts a bubble (flush wins); sync active-low reset beats both.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int DATA_W     = EX_DATA_W,
   parameter int REG_ADDR_W = EX_REG_ADDR_W
)(
   input logic         clk,
   input logic         rst_n,
   execute_stage_if.slave bus
);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] rt_fwd;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_res;

`ifdef EX_FWD_EN
   logic ex_fwd_ok;

   // A load's EX/MEM result is an address, not the loaded value, so it is never bypassed.
   assign ex_fwd_ok = bus.ex_valid & bus.ex_reg_write & ~bus.ex_mem_read;

   // Per-operand bypass: EX/MEM is newer than WB, WB newer than the register file read.
   always_comb begin
      op_a = bus.rs_val;
      if (ex_fwd_ok && (bus.ex_rd == bus.rs_addr) && (bus.rs_addr != '0))
         op_a = bus.ex_result;
      else if (bus.wb_reg_write && (bus.wb_rd == bus.rs_addr) && (bus.rs_addr != '0))
         op_a = bus.wb_data;

      rt_fwd = bus.rt_val;
      if (ex_fwd_ok && (bus.ex_rd == bus.rt_addr) && (bus.rt_addr != '0))
         rt_fwd = bus.ex_result;
      else if (bus.wb_reg_write && (bus.wb_rd == bus.rt_addr) && (bus.rt_addr != '0))
         rt_fwd = bus.wb_data;
   end
`else
   logic unused_fwd;

   assign op_a       = bus.rs_val;
   assign rt_fwd     = bus.rt_val;
   assign unused_fwd = ^{bus.rs_addr, bus.rt_addr, bus.wb_reg_write, bus.wb_rd, bus.wb_data};
`endif

   assign op_b = uses_imm(bus.Opcode) ? bus.imm : rt_fwd;

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .aluop  (bus.ALUOP),
      .a      (op_a),
      .b      (op_b),
      .result (alu_res)
   );

   // EX/MEM register: reset > flush > hold > load (bubble when the slot is empty).
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush || (!bus.hold && !bus.in_valid)) begin
         bus.ex_valid      <= 1'b0;
         bus.ex_result     <= '0;
         bus.ex_store_data <= '0;
         bus.ex_rd         <= '0;
         bus.ex_reg_write  <= 1'b0;
         bus.ex_mem_read   <= 1'b0;
         bus.ex_mem_write  <= 1'b0;
         bus.ex_zero       <= 1'b0;
      end else if (!bus.hold) begin
         bus.ex_valid      <= 1'b1;
         bus.ex_result     <= alu_res;
         bus.ex_store_data <= rt_fwd;
         bus.ex_rd         <= bus.rd_addr;
         bus.ex_reg_write  <= writes_reg(bus.Opcode) && (bus.rd_addr != '0);
         bus.ex_mem_read   <= (bus.Opcode == OP_LW);
         bus.ex_mem_write  <= (bus.Opcode == OP_SW);
         bus.ex_zero       <= (alu_res == '0);
      end
   end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipelined processor. Consumes the 3-bit ALU operation code and decoded operands from the ID/EX boundary. Selects operand B (register or immediate), computes the ALU result and registers it, with control bits, into the EX/MEM pipeline register for the memory stage. Supports hold (stall), flush (bubble insertion) and optional operand forwarding.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_ADDR_W, 3, register-file address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  ID/EX slot holds a real instruction
- Opcode  in  5  instruction opcode (ADD=0 … SW=10)
- ALUOP  in  3  000 add, 001 sub, 010 or, 011 nor, 100 and
- rs_val  in  DATA_W  register operand A
- rt_val  in  DATA_W  register operand B / store data
- imm  in  DATA_W  immediate, already extended
- rd_addr  in  REG_ADDR_W  destination register
- rs_addr, rt_addr  in  REG_ADDR_W  source registers (used only with forwarding)
- wb_reg_write  in  1  writeback stage writes a register
- wb_rd  in  REG_ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- hold  in  1  freeze EX/MEM register
- flush  in  1  insert bubble into EX/MEM
- ex_valid  out  1  EX/MEM slot valid
- ex_result  out  DATA_W  registered ALU result / memory address
- ex_store_data  out  DATA_W  registered operand B register value for SW
- ex_rd  out  REG_ADDR_W  registered destination
- ex_reg_write  out  1  registered: opcodes 0–9
- ex_mem_read  out  1  registered: LW (9)
- ex_mem_write  out  1  registered: SW (10)
- ex_zero  out  1  registered: result == 0

## Operation
- Operand B = imm for opcodes 5–10, else rt (after forwarding).
- ALU: add/sub modulo 2^DATA_W, carry/overflow discarded; or, nor, and bitwise; ALUOP 101–111 yields 0.
- Control bits decoded from Opcode; opcodes 11–31 produce reg_write=mem_read=mem_write=0.
- Register 0 is hardwired zero: rd_addr==0 forces ex_reg_write=0.
- Bubble: in_valid=0 loads valid=0 and all control bits 0; data fields don't-care, implemented as 0.
- Priority per cycle: rst_n=0 > flush > hold > normal load.
  - flush: ex_valid and control bits cleared; data fields 0.
  - hold: every EX/MEM register keeps its value.

## Timing
- Reset: every output 0 on the first rising edge with rst_n low. Reset mid-operation discards the in-flight instruction.
- Latency: 1 cycle from ID/EX inputs to ex_* outputs. Throughput 1 instruction/cycle.
- flush and hold together: flush wins.
- Load-use hazards are not resolved here; the hazard unit asserts hold/bubble upstream.

## Configuration
- EX_FWD_EN defined: operand A and operand B register values are forwarded, per operand, in this priority:
  - From EX/MEM when ex_valid & ex_reg_write & ~ex_mem_read & ex_rd==src & src!=0.
  - Else from WB when wb_reg_write & wb_rd==src & src!=0.
  - Else the ID/EX value.
  - The forwarded B value also feeds ex_store_data.
- EX_FWD_EN undefined: rs_val/rt_val used directly. rs_addr, rt_addr, wb_* are ignored.

## Structure
- Shared package: opcode constants (0–10), ALUOP encodings, DATA_W/REG_ADDR_W defaults.
- Sub-module alu_core: combinational, ALUOP + two operands -> result. Instantiated once.
- Forwarding muxes and the EX/MEM register stay in execute_stage.

## Test plan
- ADD (Opcode 0, ALUOP 000), rs=7, rt=5, rd=2, in_valid=1 -> next cycle ex_result=12, ex_rd=2, ex_reg_write=1, ex_valid=1, ex_zero=0.
- SUB rs=5, rt=5 -> ex_result=0, ex_zero=1. SUB 0−1 -> ex_result=all-ones.
- LW (Opcode 9), rs=0x100, imm=4 -> ex_result=0x104, ex_mem_read=1.
- SW (Opcode 10), rs=0x10, imm=8, rt=0xAB -> ex_result=0x18, ex_mem_write=1, ex_reg_write=0, ex_store_data=0xAB.
- hold=1 for 3 cycles after ADD, with new inputs applied -> outputs unchanged. Then flush=1 with hold=1 -> ex_valid=0, controls 0.
- rst_n=0 mid-stream -> all outputs 0 next edge.
- EX_FWD_EN: ADD r1=3+4, then ADD r2=r1+r1 with stale rs_val=0 -> ex_result=14. WB writes r3=9, EX/MEM also writes r3=5 -> EX/MEM value 5 is used.
- EX_FWD_EN: rd=0 in EX/MEM -> not forwarded.
